// File: rtl/io_port_fifo_if.sv
// Handshake bundle between the pipeline/external side and the buffered I/O port unit.
// master drives the requests and external data, slave is the unit itself.
interface io_port_fifo_if #(
    parameter int N         = 16,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
);
    logic [N-1:0]                 ext_in_data;
    logic                         ext_in_valid;
    logic                         ext_in_ready;
    logic [N-1:0]                 ext_out_data;
    logic                         ext_out_valid;
    logic                         ext_out_ready;
    logic                         wb_in_req;
    logic [N-1:0]                 wb_in_data;
    logic                         wb_out_req;
    logic [N-1:0]                 wb_out_data;
    logic                         stall;
    logic [$clog2(IN_DEPTH):0]    in_count;
    logic [$clog2(OUT_DEPTH):0]   out_count;
    logic                         proto_err;

    modport master (
        output ext_in_data, ext_in_valid, ext_out_ready,
        output wb_in_req, wb_out_req, wb_out_data,
        input  ext_in_ready, ext_out_data, ext_out_valid,
        input  wb_in_data, stall, in_count, out_count, proto_err
    );

    modport slave (
        input  ext_in_data, ext_in_valid, ext_out_ready,
        input  wb_in_req, wb_out_req, wb_out_data,
        output ext_in_ready, ext_out_data, ext_out_valid,
        output wb_in_data, stall, in_count, out_count, proto_err
    );
endinterface

// File: rtl/io_port_fifo_unit.sv
// io_port_fifo_sync: generic circular FIFO, head reads as zero when empty.
// Latency: 1 cycle push-to-visible, no fall-through.
// Backpressure: push ignored when full (even with a same-cycle pop), pop ignored when empty.
module io_port_fifo_sync #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [W-1:0]              wr_dat,
    input  logic                      pop,
    output logic [W-1:0]              rd_dat,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign count   = cnt;
    assign rd_dat  = empty ? '0 : mem[rd_ptr];

    // Storage is deliberately not reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// io_port_fifo_unit: buffered IN/OUT port beside WB, input and output FIFOs plus stall generation.
// Latency: 1 cycle through either FIFO, 1 word/cycle/direction.
// Backpressure: ext_in_ready = !in_full; stall when IN finds input empty or OUT finds output full.
module io_port_fifo_unit #(
    parameter int N         = 16,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    io_port_fifo_if.slave port
);
    logic in_full;
    logic in_empty;
    logic out_full;
    logic out_empty;
    logic in_push;
    logic in_pop;
    logic out_push;
    logic out_pop;
    logic stall_int;
    logic proto_q;

    // Stall derives only from registered occupancy flags, never from same-cycle pops.
    assign stall_int = (port.wb_in_req & in_empty) | (port.wb_out_req & out_full);

    assign in_push  = port.ext_in_valid & ~in_full;
    assign in_pop   = port.wb_in_req & ~stall_int;
    assign out_push = port.wb_out_req & ~stall_int;
    assign out_pop  = ~out_empty & port.ext_out_ready;

    assign port.ext_in_ready  = ~in_full;
    assign port.ext_out_valid = ~out_empty;
    assign port.stall         = stall_int;
    assign port.proto_err     = proto_q;

    io_port_fifo_sync #(
        .W     (N),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (in_push),
        .wr_dat (port.ext_in_data),
        .pop    (in_pop),
        .rd_dat (port.wb_in_data),
        .full   (in_full),
        .empty  (in_empty),
        .count  (port.in_count)
    );

    io_port_fifo_sync #(
        .W     (N),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (out_push),
        .wr_dat (port.wb_out_data),
        .pop    (out_pop),
        .rd_dat (port.ext_out_data),
        .full   (out_full),
        .empty  (out_empty),
        .count  (port.out_count)
    );

    // IN and OUT in the same WB cycle cannot come from a legal instruction stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_q <= 1'b0;
        end else if (port.wb_in_req & port.wb_out_req) begin
            proto_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_io_port_fifo_unit.sv
// Bench for io_port_fifo_unit: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_io_port_fifo_unit;
    localparam int N  = 16;
    localparam int ID = 4;
    localparam int OD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    io_port_fifo_if #(.N(N), .IN_DEPTH(ID), .OUT_DEPTH(OD)) bus();

    io_port_fifo_unit #(.N(N), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
        .clk  (clk),
        .rst  (rst),
        .port (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two word queues and a sticky flag.
    logic [N-1:0] in_q[$];
    logic [N-1:0] out_q[$];
    logic         proto_m = 1'b0;

    always @(negedge clk) begin
        logic stall_m;
        logic push_i, pop_i, push_o, pop_o;
        if (rst) begin
            in_q.delete();
            out_q.delete();
            proto_m = 1'b0;
        end
        stall_m = (bus.wb_in_req && in_q.size() == 0) || (bus.wb_out_req && out_q.size() == OD);
        check("ext_in_ready",  32'(bus.ext_in_ready),  32'(in_q.size() < ID));
        check("ext_out_valid", 32'(bus.ext_out_valid), 32'(out_q.size() != 0));
        check("ext_out_data",  32'(bus.ext_out_data),  out_q.size() != 0 ? 32'(out_q[0]) : 32'd0);
        check("wb_in_data",    32'(bus.wb_in_data),    in_q.size() != 0 ? 32'(in_q[0]) : 32'd0);
        check("stall",         32'(bus.stall),         32'(stall_m));
        check("in_count",      32'(bus.in_count),      32'(in_q.size()));
        check("out_count",     32'(bus.out_count),     32'(out_q.size()));
        check("proto_err",     32'(bus.proto_err),     32'(proto_m));
        if (!rst) begin
            push_i = bus.ext_in_valid && in_q.size() < ID;
            pop_i  = bus.wb_in_req && !stall_m;
            push_o = bus.wb_out_req && !stall_m;
            pop_o  = bus.ext_out_ready && out_q.size() != 0;
            if (pop_i)  void'(in_q.pop_front());
            if (pop_o)  void'(out_q.pop_front());
            if (push_i) in_q.push_back(bus.ext_in_data);
            if (push_o) out_q.push_back(bus.wb_out_data);
            if (bus.wb_in_req && bus.wb_out_req) proto_m = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] exp_words [5];

    initial begin
        logic held;
        bus.ext_in_data   = '0;
        bus.ext_in_valid  = 1'b0;
        bus.ext_out_ready = 1'b0;
        bus.wb_in_req     = 1'b0;
        bus.wb_out_req    = 1'b0;
        bus.wb_out_data   = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst ext_in_ready",  32'(bus.ext_in_ready), 32'd1);
        check("rst ext_out_valid", 32'(bus.ext_out_valid), 32'd0);
        check("rst in_count",      32'(bus.in_count), 32'd0);
        check("rst out_count",     32'(bus.out_count), 32'd0);
        check("rst stall",         32'(bus.stall), 32'd0);
        check("rst proto_err",     32'(bus.proto_err), 32'd0);

        // Fill the input FIFO, then drain it through IN
        exp_words[0] = 16'h1111; exp_words[1] = 16'h2222;
        exp_words[2] = 16'h3333; exp_words[3] = 16'h4444;
        bus.ext_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ext_in_data = exp_words[i];
            step();
        end
        bus.ext_in_valid = 1'b0;
        check("fill in_count", 32'(bus.in_count), 32'd4);
        check("fill ext_in_ready", 32'(bus.ext_in_ready), 32'd0);
        bus.wb_in_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain wb_in_data", 32'(bus.wb_in_data), 32'(exp_words[i]));
            step();
        end
        bus.wb_in_req = 1'b0;
        check("drain in_count", 32'(bus.in_count), 32'd0);

        // IN on empty FIFO stalls until a word arrives
        bus.wb_in_req = 1'b1;
        check("in empty stall", 32'(bus.stall), 32'd1);
        step();
        step();
        check("in empty stall held", 32'(bus.stall), 32'd1);
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'hBEEF;
        step();
        bus.ext_in_valid = 1'b0;
        check("beef stall", 32'(bus.stall), 32'd0);
        check("beef wb_in_data", 32'(bus.wb_in_data), 32'hBEEF);
        step();
        bus.wb_in_req = 1'b0;
        check("beef in_count", 32'(bus.in_count), 32'd0);

        // OUT into a full output FIFO
        exp_words[0] = 16'hA; exp_words[1] = 16'hB; exp_words[2] = 16'hC;
        exp_words[3] = 16'hD; exp_words[4] = 16'hE;
        bus.ext_out_ready = 1'b0;
        bus.wb_out_req    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wb_out_data = exp_words[i];
            step();
        end
        bus.wb_out_data = exp_words[4];
        check("out full count", 32'(bus.out_count), 32'd4);
        check("out full stall", 32'(bus.stall), 32'd1);
        step();
        check("out full stall held", 32'(bus.stall), 32'd1);
        bus.ext_out_ready = 1'b1;
        check("out full stall w/ ready", 32'(bus.stall), 32'd1);
        check("out head A", 32'(bus.ext_out_data), 32'hA);
        step();
        check("out stall drop", 32'(bus.stall), 32'd0);
        check("out count after pop", 32'(bus.out_count), 32'd3);
        check("out head B", 32'(bus.ext_out_data), 32'hB);
        step();
        bus.wb_out_req = 1'b0;
        for (int i = 2; i < 5; i++) begin
            check("out emit order", 32'(bus.ext_out_data), 32'(exp_words[i]));
            step();
        end
        check("out drained count", 32'(bus.out_count), 32'd0);
        check("out drained valid", 32'(bus.ext_out_valid), 32'd0);
        bus.ext_out_ready = 1'b0;

        // Simultaneous push and pop at in_count=2
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'h0055;
        step();
        bus.ext_in_data  = 16'h0066;
        step();
        bus.wb_in_req = 1'b1;
        exp_words[0] = 16'h0055; exp_words[1] = 16'h0066; exp_words[2] = 16'h0077;
        exp_words[3] = 16'h0088; exp_words[4] = 16'h0099;
        for (int i = 0; i < 3; i++) begin
            bus.ext_in_data = exp_words[i + 2];
            check("pp in_count", 32'(bus.in_count), 32'd2);
            check("pp order", 32'(bus.wb_in_data), 32'(exp_words[i]));
            step();
        end
        bus.ext_in_valid = 1'b0;
        check("pp in_count end", 32'(bus.in_count), 32'd2);
        for (int i = 3; i < 5; i++) begin
            check("pp drain order", 32'(bus.wb_in_data), 32'(exp_words[i]));
            step();
        end
        bus.wb_in_req = 1'b0;
        check("pp in_count empty", 32'(bus.in_count), 32'd0);

        // Illegal simultaneous IN/OUT, then reset mid-stream
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'h1234;
        step();
        bus.ext_in_valid = 1'b0;
        bus.wb_in_req    = 1'b1;
        bus.wb_out_req   = 1'b1;
        bus.wb_out_data  = 16'h4321;
        step();
        bus.wb_in_req  = 1'b0;
        bus.wb_out_req = 1'b0;
        check("proto set", 32'(bus.proto_err), 32'd1);
        check("proto out_count", 32'(bus.out_count), 32'd1);
        step();
        step();
        check("proto sticky", 32'(bus.proto_err), 32'd1);
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'h5A5A;
        step();
        step();
        bus.ext_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid rst in_count", 32'(bus.in_count), 32'd0);
        check("mid rst out_count", 32'(bus.out_count), 32'd0);
        check("mid rst proto", 32'(bus.proto_err), 32'd0);
        check("mid rst out_valid", 32'(bus.ext_out_valid), 32'd0);
        check("mid rst out_data", 32'(bus.ext_out_data), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Randomized traffic; a stalled request is held until it completes
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            held = bus.stall;
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 699) == 0);
            bus.ext_in_valid  = ($urandom_range(0, 99) < 60);
            bus.ext_in_data   = N'($urandom);
            bus.ext_out_ready = ($urandom_range(0, 99) < 50);
            if (!held || rst) begin
                int r;
                r = $urandom_range(0, 9);
                bus.wb_in_req   = (r < 3);
                bus.wb_out_req  = (r >= 3 && r < 6);
                bus.wb_out_data = N'($urandom);
            end
        end
        rst = 1'b0;
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
